// File: rtl/jt51_lfo_apply.sv
// Applies LFO amplitude and phase modulation per slot using each slot's AMS/PMS sensitivity.
// Define JT51_LFO_SNAPSHOT_EN to freeze am/pm_u once per 32-slot round, captured when zero is high.
module jt51_lfo_apply #(
    parameter int SAT_MAX = 6143
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic [6:0] am,
    input  logic [7:0] pm_u,
    input  logic [2:0] pms,
    input  logic [1:0] ams,
    input  logic       amsen,
    input  logic [6:0] kc,
    input  logic [5:0] kf,
    output logic [6:0] kc_out,
    output logic [5:0] kf_out,
    output logic [9:0] am_att,
    output logic       zero_out
);

    logic [6:0] am_act;
    logic [7:0] pm_act;

`ifdef JT51_LFO_SNAPSHOT_EN
    logic [6:0] am_s_q;
    logic [7:0] pm_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            am_s_q <= '0;
            pm_s_q <= '0;
        end else if (cen && zero) begin
            am_s_q <= am;
            pm_s_q <= pm_u;
        end
    end

    // Slot 0 uses the live value; it is the same value that gets captured.
    assign am_act = zero ? am   : am_s_q;
    assign pm_act = zero ? pm_u : pm_s_q;
`else
    assign am_act = am;
    assign pm_act = pm_u;
`endif

    // Stage 1 registers
    logic [2:0] s1_pms_q;
    logic [1:0] s1_ams_q;
    logic       s1_amsen_q, s1_zero_q;
    logic [6:0] s1_kc_q, s1_am_q;
    logic [5:0] s1_kf_q;
    logic [7:0] s1_pm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_pms_q   <= '0;
            s1_ams_q   <= '0;
            s1_amsen_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_kc_q    <= '0;
            s1_kf_q    <= '0;
            s1_am_q    <= '0;
            s1_pm_q    <= '0;
        end else if (cen) begin
            s1_pms_q   <= pms;
            s1_ams_q   <= ams;
            s1_amsen_q <= amsen;
            s1_zero_q  <= zero;
            s1_kc_q    <= kc;
            s1_kf_q    <= kf;
            s1_am_q    <= am_act;
            s1_pm_q    <= pm_act;
        end
    end

    // Stage 2: linearise pitch, scale PM offset and AM attenuation
    logic [3:0]  note_n;
    logic [12:0] lin_d;
    logic [8:0]  off_d;
    logic [9:0]  am_d;

    always_comb begin
        note_n = 4'd0;
        case (s1_kc_q[3:0])
            4'd0:  note_n = 4'd0;
            4'd1:  note_n = 4'd1;
            4'd2, 4'd3:   note_n = 4'd2;
            4'd4:  note_n = 4'd3;
            4'd5:  note_n = 4'd4;
            4'd6, 4'd7:   note_n = 4'd5;
            4'd8:  note_n = 4'd6;
            4'd9:  note_n = 4'd7;
            4'd10, 4'd11: note_n = 4'd8;
            4'd12: note_n = 4'd9;
            4'd13: note_n = 4'd10;
            default:      note_n = 4'd11;
        endcase
        lin_d = 13'(s1_kc_q[6:4]) * 13'd768 + {3'b000, note_n, 6'b000000} + {7'b0000000, s1_kf_q};

        off_d = 9'd0;
        case (s1_pms_q)
            3'd0: off_d = 9'd0;
            3'd1: off_d = 9'(s1_pm_q[6:0] >> 5);
            3'd2: off_d = 9'(s1_pm_q[6:0] >> 4);
            3'd3: off_d = 9'(s1_pm_q[6:0] >> 3);
            3'd4: off_d = 9'(s1_pm_q[6:0] >> 2);
            3'd5: off_d = 9'(s1_pm_q[6:0] >> 1);
            3'd6: off_d = {1'b0, s1_pm_q[6:0], 1'b0};
            default: off_d = {s1_pm_q[6:0], 2'b00};
        endcase

        am_d = 10'd0;
        if (s1_amsen_q) begin
            case (s1_ams_q)
                2'd0: am_d = 10'd0;
                2'd1: am_d = {3'b000, s1_am_q};
                2'd2: am_d = {2'b00, s1_am_q, 1'b0};
                default: am_d = {1'b0, s1_am_q, 2'b00};
            endcase
        end
    end

    logic [12:0] s2_lin_q;
    logic [8:0]  s2_off_q;
    logic        s2_sign_q, s2_zero_q;
    logic [9:0]  s2_am_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_lin_q  <= '0;
            s2_off_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_am_q   <= '0;
        end else if (cen) begin
            s2_lin_q  <= lin_d;
            s2_off_q  <= off_d;
            s2_sign_q <= s1_pm_q[7];
            s2_zero_q <= s1_zero_q;
            s2_am_q   <= am_d;
        end
    end

    // Stage 3: add with saturation, then split back into octave/note/fraction
    logic signed [13:0] sum;
    logic [12:0] sat;
    logic [2:0]  oct_d;
    logic [12:0] rem;
    logic [3:0]  n_out;
    logic [3:0]  note_code;

    always_comb begin
        if (s2_sign_q)
            sum = $signed({1'b0, s2_lin_q}) - $signed({5'b00000, s2_off_q});
        else
            sum = $signed({1'b0, s2_lin_q}) + $signed({5'b00000, s2_off_q});

        if (sum < 14'sd0)
            sat = 13'd0;
        else if (sum > $signed(14'(SAT_MAX)))
            sat = 13'(SAT_MAX);
        else
            sat = sum[12:0];

        oct_d = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (sat >= 13'(k * 768))
                oct_d = 3'(k);
        end
        rem   = sat - 13'(oct_d) * 13'd768;
        n_out = rem[9:6];

        note_code = 4'd14;
        case (n_out)
            4'd0, 4'd1, 4'd2:   note_code = n_out;
            4'd3, 4'd4, 4'd5:   note_code = n_out + 4'd1;
            4'd6, 4'd7, 4'd8:   note_code = n_out + 4'd2;
            4'd9, 4'd10, 4'd11: note_code = n_out + 4'd3;
            default:            note_code = 4'd14;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_out   <= '0;
            kf_out   <= '0;
            am_att   <= '0;
            zero_out <= 1'b0;
        end else if (cen) begin
            kc_out   <= {oct_d, note_code};
            kf_out   <= rem[5:0];
            am_att   <= s2_am_q;
            zero_out <= s2_zero_q;
        end
    end

endmodule

// File: tb/tb_jt51_lfo_apply.sv
// Self-checking bench for jt51_lfo_apply: directed cases plus randomized traffic against an arithmetic model.
module tb_jt51_lfo_apply;
    logic       clk = 1'b0, rst = 1'b1, cen = 1'b0, zero = 1'b0;
    logic [6:0] am = '0;
    logic [7:0] pm_u = '0;
    logic [2:0] pms = '0;
    logic [1:0] ams = '0;
    logic       amsen = 1'b0;
    logic [6:0] kc = '0;
    logic [5:0] kf = '0;
    logic [6:0] kc_out;
    logic [5:0] kf_out;
    logic [9:0] am_att;
    logic       zero_out;
    logic [23:0] obs;

    int vectors = 0, miscompares = 0;
    logic [23:0] q[$];
    logic [23:0] cur_exp;
    int snap_am, snap_pm;

    jt51_lfo_apply dut (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .am(am), .pm_u(pm_u),
        .pms(pms), .ams(ams), .amsen(amsen), .kc(kc), .kf(kf),
        .kc_out(kc_out), .kf_out(kf_out), .am_att(am_att), .zero_out(zero_out)
    );

    always #5 clk = ~clk;
    assign obs = {kc_out, kf_out, am_att, zero_out};

    // Reference: plain integer pitch arithmetic, result packed as {kc,kf,am_att,zero}
    function automatic logic [23:0] model(input int a, input int p, input int ps, input int as,
                                          input int en, input int k, input int f, input int z);
        int nib, n, lin, mag, off, res, o, rem, att;
        nib = k % 16;
        n = nib - nib / 4;
        if (nib % 4 == 3) n = n - 1;
        lin = (k / 16) * 768 + n * 64 + f;
        mag = p % 128;
        if (ps == 0) off = 0;
        else if (ps <= 5) off = mag / (1 << (6 - ps));
        else off = mag * ((ps == 6) ? 2 : 4);
        res = (p >= 128) ? lin - off : lin + off;
        if (res < 0) res = 0;
        if (res > 6143) res = 6143;
        o = res / 768;
        rem = res % 768;
        n = rem / 64;
        att = (en != 0 && as != 0) ? a * (1 << (as - 1)) : 0;
        return {7'(o * 16 + n + n / 3), 6'(rem % 64), 10'(att), 1'(z)};
    endfunction

    task automatic reset_model();
        q.delete();
        q.push_back(24'd0);
        q.push_back(24'd0);
        cur_exp = 24'd0;
        snap_am = 0;
        snap_pm = 0;
    endtask

    task automatic tick(input logic c);
        int a, p;
        cen = c;
        @(posedge clk);
        #1;
        if (c) begin
            a = int'(am);
            p = int'(pm_u);
`ifdef JT51_LFO_SNAPSHOT_EN
            if (zero) begin
                snap_am = a;
                snap_pm = p;
            end else begin
                a = snap_am;
                p = snap_pm;
            end
`endif
            q.push_back(model(a, p, int'(pms), int'(ams), int'(amsen), int'(kc), int'(kf), int'(zero)));
            cur_exp = q.pop_front();
        end
    endtask

    task automatic set_vec(input logic z, input logic [6:0] a, input logic [7:0] p, input logic [2:0] ps,
                           input logic [1:0] as, input logic en, input logic [6:0] k, input logic [5:0] f);
        zero = z; am = a; pm_u = p; pms = ps; ams = as; amsen = en; kc = k; kf = f;
    endtask

    task automatic randomize_inputs();
        zero  = ($urandom_range(0, 7) == 0);
        am    = 7'($urandom);
        pm_u  = 8'($urandom);
        pms   = 3'($urandom);
        ams   = 2'($urandom);
        amsen = 1'($urandom);
        kc    = 7'($urandom);
        kf    = 6'($urandom);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (obs !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 000000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_passthrough();
        set_vec(1'b0, 7'h00, 8'h7F, 3'd0, 2'd0, 1'b1, 7'h4A, 6'h10);
        repeat (3) tick(1'b1);
        vectors++;
        if ({kc_out, kf_out, am_att} !== {7'h4A, 6'h10, 10'h000}) begin
            miscompares++;
            $display("FAIL passthrough: got kc %h kf %h am %h want 4a 10 000", kc_out, kf_out, am_att);
        end
    endtask

    task automatic test_pm();
        set_vec(1'b1, 7'h00, 8'h05, 3'd7, 2'd0, 1'b0, 7'h40, 6'h3C);
        repeat (3) tick(1'b1);
        vectors++;
        if ({kc_out, kf_out} !== {7'h41, 6'h10}) begin
            miscompares++;
            $display("FAIL pm_positive: got kc %h kf %h want 41 10", kc_out, kf_out);
        end
        pm_u = 8'h85;
        repeat (3) tick(1'b1);
        vectors++;
        if ({kc_out, kf_out} !== {7'h40, 6'h28}) begin
            miscompares++;
            $display("FAIL pm_negative: got kc %h kf %h want 40 28", kc_out, kf_out);
        end
    endtask

    task automatic test_saturation();
        set_vec(1'b1, 7'h00, 8'h7F, 3'd7, 2'd0, 1'b0, 7'h7E, 6'h3F);
        repeat (3) tick(1'b1);
        vectors++;
        if ({kc_out, kf_out} !== {7'h7E, 6'h3F}) begin
            miscompares++;
            $display("FAIL sat_high: got kc %h kf %h want 7e 3f", kc_out, kf_out);
        end
        set_vec(1'b1, 7'h00, 8'hFF, 3'd7, 2'd0, 1'b0, 7'h00, 6'h00);
        repeat (3) tick(1'b1);
        vectors++;
        if ({kc_out, kf_out} !== {7'h00, 6'h00}) begin
            miscompares++;
            $display("FAIL sat_low: got kc %h kf %h want 00 00", kc_out, kf_out);
        end
        set_vec(1'b1, 7'h00, 8'h00, 3'd0, 2'd0, 1'b0, 7'h23, 6'h00);
        repeat (3) tick(1'b1);
        vectors++;
        if (kc_out !== 7'h22) begin
            miscompares++;
            $display("FAIL illegal_note: got kc %h want 22", kc_out);
        end
    endtask

    task automatic test_am();
        set_vec(1'b1, 7'h7F, 8'h00, 3'd0, 2'd3, 1'b1, 7'h10, 6'h00);
        repeat (3) tick(1'b1);
        vectors++;
        if (am_att !== 10'h1FC) begin
            miscompares++;
            $display("FAIL am_ams3: got %h want 1fc", am_att);
        end
        amsen = 1'b0;
        repeat (3) tick(1'b1);
        vectors++;
        if (am_att !== 10'h000) begin
            miscompares++;
            $display("FAIL am_disabled: got %h want 000", am_att);
        end
        amsen = 1'b1;
        ams = 2'd1;
        repeat (3) tick(1'b1);
        vectors++;
        if (am_att !== 10'h07F) begin
            miscompares++;
            $display("FAIL am_ams1: got %h want 07f", am_att);
        end
    endtask

    task automatic test_snapshot();
        logic [9:0] later;
`ifdef JT51_LFO_SNAPSHOT_EN
        later = 10'h010;
`else
        later = 10'h050;
`endif
        set_vec(1'b1, 7'h10, 8'h00, 3'd0, 2'd1, 1'b1, 7'h10, 6'h00);
        tick(1'b1);
        zero = 1'b0;
        am = 7'h50;
        repeat (2) tick(1'b1);
        vectors++;
        if (am_att !== 10'h010) begin
            miscompares++;
            $display("FAIL snap_zero_slot: got %h want 010", am_att);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            vectors++;
            if (am_att !== later) begin
                miscompares++;
                $display("FAIL snap_mid_round: got %h want %h", am_att, later);
            end
        end
        zero = 1'b1;
        tick(1'b1);
        zero = 1'b0;
        repeat (2) tick(1'b1);
        vectors++;
        if (am_att !== 10'h050) begin
            miscompares++;
            $display("FAIL snap_next_round: got %h want 050", am_att);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_inputs();
            tick(($urandom_range(0, 3) != 0));
            vectors++;
            if (obs !== cur_exp) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, cur_exp);
            end
        end
    endtask

    task automatic test_cen_hold();
        randomize_inputs();
        tick(1'b1);
        for (int i = 0; i < 5; i++) begin
            randomize_inputs();
            tick(1'b0);
            vectors++;
            if (obs !== cur_exp) begin
                miscompares++;
                $display("FAIL cen_hold[%0d]: got %h want %h", i, obs, cur_exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            tick(1'b1);
            vectors++;
            if (obs !== cur_exp) begin
                miscompares++;
                $display("FAIL cen_resume[%0d]: got %h want %h", i, obs, cur_exp);
            end
        end
    endtask

    task automatic test_midreset();
        set_vec(1'b1, 7'h7F, 8'h7F, 3'd7, 2'd3, 1'b1, 7'h55, 6'h2A);
        repeat (3) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 24'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 000000", obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        randomize_inputs();
        tick(1'b1);
        vectors++;
        if (obs !== cur_exp) begin
            miscompares++;
            $display("FAIL after_reset: got %h want %h", obs, cur_exp);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_pm();
        test_saturation();
        test_am();
        test_snapshot();
        test_random(400);
        test_cen_hold();
        test_midreset();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
